scan_sequencer: RTL and testbench
=================================

Name: scan_sequencer

Overview:
Sequential address generator that drives a 4-to-16 decoder's select input (4-bit) and enable input. It steps through indices 0..last_idx, holding enable high for a programmable dwell time per index, with an optional blanking gap between indices. It supports single-pass and continuous modes, so the one-hot decoder outputs can scan an LED/keypad matrix or a chip-select bank.

Parameters:
DWELL_W, 8, width of dwell count input
BLANK_CYCLES, 1, cycles with en low between consecutive indices; 0 = no gap

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a scan; sampled only in IDLE
stop  input  1  abort the scan; sampled in any state
continuous  input  1  1 = wrap and rescan forever, 0 = single pass; latched at start
dwell  input  DWELL_W  en-high cycles per index, 0 treated as 1; latched at start
last_idx  input  4  final index of the scan (0..15); latched at start
addr  output  4  decoder select (a)
en  output  1  decoder enable
busy  output  1  high while not IDLE
step  output  1  one-cycle pulse when addr advances (including wrap)
done  output  1  one-cycle pulse at normal end of a single-pass scan

Behaviour:
- All outputs registered. On rst: addr=0, en=0, busy=0, step=0, done=0, state=IDLE, latched regs=0.
- FSM states: IDLE, ACTIVE, BLANK.
- IDLE: en=0, busy=0. If start=1 and stop=0, latch continuous/dwell/last_idx. Next cycle: ACTIVE, addr=0, en=1, busy=1. Latency from start to en high is 1 clock.
- ACTIVE: en=1 for exactly max(dwell,1) cycles, counted by a DWELL_W-bit down-counter. At expiry:
  - BLANK_CYCLES>0: go to BLANK.
  - BLANK_CYCLES=0: advance directly (see advance rule). en stays high across the index change.
- BLANK: en=0 for exactly BLANK_CYCLES cycles; addr holds the old value; then advance.
- Advance rule:
  - addr!=last_idx: addr+1, step=1, back to ACTIVE.
  - addr==last_idx and continuous: addr=0, step=1, ACTIVE.
  - addr==last_idx and single pass: IDLE, done=1 on the same cycle busy falls, addr holds last_idx, no step.
- Single-pass final index with BLANK_CYCLES>0: the final blank still runs before done.
- last_idx=0: one index only. Continuous mode re-dwells on 0 with step pulsing at each wrap.
- stop=1 in ACTIVE/BLANK: next cycle IDLE, en=0, busy=0, no done, no step. addr holds its current value.
- stop and start asserted together in IDLE: stop wins, remains IDLE.
- start while busy: ignored. Changes to dwell/last_idx/continuous while busy have no effect until the next start.
- After done or stop, a new start always restarts from addr=0.
- rst mid-scan: immediate return to reset values, asynchronously.
- Counter widths: dwell counter DWELL_W bits; blank counter $clog2(BLANK_CYCLES+1) bits, minimum 1.

Decomposition:
- Shared package scan_pkg: state enum (IDLE=2'd0, ACTIVE=2'd1, BLANK=2'd2), ADDR_W=4, MAX_IDX=4'd15.
- One natural sub-module: dwell_timer. It is a loadable down-counter with load, count-enable and an expired flag. It is instantiated twice, for dwell and for blank. No other hierarchy.

Test Plan:
1. Reset, then start with dwell=3, last_idx=2, continuous=0, BLANK_CYCLES=1 -> en pattern 1110 per index, addr 0,0,0,0,1,1,1,1,2,2,2,2; step pulses at addr 1 and 2; done one pulse 13 cycles after start; busy falls with done.
2. dwell=0, last_idx=0, continuous=0 -> en high 1 cycle, blank 1 cycle, done; no step.
3. continuous=1, dwell=2, last_idx=15 -> addr wraps 15->0 with step pulse; no done ever; en never high with BLANK active.
4. stop asserted at the 2nd cycle of index 5 -> next cycle en=0, busy=0, addr=5, no done. A following start resumes at addr=0.
5. start pulsed while busy, and start+stop in IDLE -> no restart, no latch change; remains IDLE in the second case.
6. Async rst asserted mid-ACTIVE between clock edges -> outputs zero immediately without waiting for clk. Recompile with BLANK_CYCLES=0 -> en stays continuously high across index changes and step still pulses.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the decoder scan sequencer.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

    localparam int ADDR_W = 4;
    localparam logic [ADDR_W-1:0] MAX_IDX = 4'd15;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that parks at zero; expired is high whenever the count is zero.
module dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         cnt_en,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (cnt_en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Steps a 4-to-16 decoder select through 0..last_idx with a programmable dwell
// per index and an optional blanking gap, in single-pass or continuous mode.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [ADDR_W-1:0]  last_idx,
    output logic [ADDR_W-1:0]  addr,
    output logic               en,
    output logic               busy,
    output logic               step,
    output logic               done,
    output state_t             state
);

    localparam int BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LOAD =
        (BLANK_CYCLES > 0) ? BLANK_W'(BLANK_CYCLES - 1) : '0;

    // Timers count down to zero, so a dwell of N is loaded as N-1 (0 behaves as 1).
    function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

    state_t              state_d;
    logic                cont_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic [ADDR_W-1:0]   last_q;

    logic                start_ok, abort, go_blank, do_adv, adv_done, at_last;
    logic                dwell_load, dwell_cnt, dwell_exp;
    logic                blank_cnt, blank_exp;
    logic [DWELL_W-1:0]  dwell_load_val;

    logic [ADDR_W-1:0]   addr_d;
    logic                en_d, busy_d, step_d, done_d;

    dwell_timer #(.W(DWELL_W)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (dwell_load),
        .load_val (dwell_load_val),
        .cnt_en   (dwell_cnt),
        .expired  (dwell_exp)
    );

    dwell_timer #(.W(BLANK_W)) u_blank (
        .clk      (clk),
        .rst      (rst),
        .load     (go_blank),
        .load_val (BLANK_LOAD),
        .cnt_en   (blank_cnt),
        .expired  (blank_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        start_ok  = 1'b0;
        abort     = 1'b0;
        go_blank  = 1'b0;
        do_adv    = 1'b0;
        dwell_cnt = 1'b0;
        blank_cnt = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    start_ok = 1'b1;
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (stop) begin
                    abort = 1'b1;
                end else if (dwell_exp) begin
                    if (BLANK_CYCLES > 0) go_blank = 1'b1;
                    else                  do_adv   = 1'b1;
                end else begin
                    dwell_cnt = 1'b1;
                end
            end
            BLANK: begin
                if (stop)           abort     = 1'b1;
                else if (blank_exp) do_adv    = 1'b1;
                else                blank_cnt = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        at_last  = (addr == last_q);
        adv_done = do_adv && at_last && !cont_q;

        if (abort || adv_done) state_d = IDLE;
        else if (go_blank)     state_d = BLANK;
        else if (do_adv)       state_d = ACTIVE;

        dwell_load     = start_ok || (do_adv && !adv_done);
        dwell_load_val = start_ok ? dwell_reload(dwell) : dwell_reload(dwell_q);
    end

    always_comb begin
        addr_d = addr;
        en_d   = en;
        busy_d = busy;
        step_d = 1'b0;
        done_d = 1'b0;
        if (start_ok) begin
            addr_d = '0;
            en_d   = 1'b1;
            busy_d = 1'b1;
        end else if (abort) begin
            en_d   = 1'b0;
            busy_d = 1'b0;
        end else if (go_blank) begin
            en_d   = 1'b0;
        end else if (adv_done) begin
            en_d   = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
        end else if (do_adv) begin
            addr_d = at_last ? '0 : addr + ADDR_W'(1);
            en_d   = 1'b1;
            step_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr    <= '0;
            en      <= 1'b0;
            busy    <= 1'b0;
            step    <= 1'b0;
            done    <= 1'b0;
            cont_q  <= 1'b0;
            dwell_q <= '0;
            last_q  <= '0;
        end else begin
            addr <= addr_d;
            en   <= en_d;
            busy <= busy_d;
            step <= step_d;
            done <= done_d;
            if (start_ok) begin
                cont_q  <= continuous;
                dwell_q <= dwell;
                last_q  <= last_idx;
            end
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: one instance with a one-cycle blank gap and one
// without, both driven by the same inputs and each checked every cycle.
module tb_scan_sequencer;
    import scan_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       continuous = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [3:0] last_idx = 4'd0;

    logic [3:0] addr_o  [2];
    logic       en_o    [2];
    logic       busy_o  [2];
    logic       step_o  [2];
    logic       done_o  [2];
    state_t     state_o [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_sequencer #(.DWELL_W(8), .BLANK_CYCLES(1)) dut_b1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .dwell(dwell), .last_idx(last_idx), .addr(addr_o[0]), .en(en_o[0]),
        .busy(busy_o[0]), .step(step_o[0]), .done(done_o[0]), .state(state_o[0])
    );

    scan_sequencer #(.DWELL_W(8), .BLANK_CYCLES(0)) dut_b0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .dwell(dwell), .last_idx(last_idx), .addr(addr_o[1]), .en(en_o[1]),
        .busy(busy_o[1]), .step(step_o[1]), .done(done_o[1]), .state(state_o[1])
    );

    // Reference model: a scan is described by its elapsed cycle count t since
    // the start edge; every output follows from t by division into periods.
    typedef struct packed {
        logic [3:0] addr;
        logic       en;
        logic       busy;
        logic       step;
        logic       done;
        logic [1:0] st;
    } exp_t;

    int         blk       [2] = '{1, 0};
    bit         scanning  [2];
    int         t         [2];
    int         md        [2];
    int         ml        [2];
    bit         mc        [2];
    logic [3:0] idle_addr [2];

    function automatic exp_t model_out(int k);
        exp_t e;
        int p, total, idx, phase;
        e = '0;
        if (!scanning[k]) begin
            e.addr = idle_addr[k];
            e.st   = IDLE;
            return e;
        end
        p     = md[k] + blk[k];
        total = (ml[k] + 1) * p;
        if (!mc[k] && t[k] == total) begin
            e.addr = 4'(ml[k]);
            e.done = 1'b1;
            e.st   = IDLE;
            return e;
        end
        idx    = mc[k] ? (t[k] / p) % (ml[k] + 1) : t[k] / p;
        phase  = t[k] % p;
        e.addr = 4'(idx);
        e.en   = (phase < md[k]);
        e.busy = 1'b1;
        e.step = (t[k] > 0) && (phase == 0);
        e.st   = e.en ? ACTIVE : BLANK;
        return e;
    endfunction

    task automatic model_edge(int k);
        exp_t e;
        bit   eff_idle;
        e = model_out(k);
        eff_idle = !e.busy;
        if (eff_idle) begin
            idle_addr[k] = e.addr;
            scanning[k]  = 1'b0;
            if (start && !stop) begin
                scanning[k] = 1'b1;
                t[k]  = 0;
                md[k] = (dwell == 8'd0) ? 1 : int'(dwell);
                ml[k] = int'(last_idx);
                mc[k] = continuous;
            end
        end else if (stop) begin
            idle_addr[k] = e.addr;
            scanning[k]  = 1'b0;
        end else begin
            t[k]++;
        end
    endtask

    task automatic reset_models();
        for (int k = 0; k < 2; k++) begin
            scanning[k]  = 1'b0;
            t[k]         = 0;
            idle_addr[k] = 4'd0;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e = model_out(k);
            chk($sformatf("blank%0d addr", blk[k]), 32'(addr_o[k]), 32'(e.addr));
            chk($sformatf("blank%0d en", blk[k]), 32'(en_o[k]), 32'(e.en));
            chk($sformatf("blank%0d busy", blk[k]), 32'(busy_o[k]), 32'(e.busy));
            chk($sformatf("blank%0d step", blk[k]), 32'(step_o[k]), 32'(e.step));
            chk($sformatf("blank%0d done", blk[k]), 32'(done_o[k]), 32'(e.done));
            chk($sformatf("blank%0d state", blk[k]), 32'(state_o[k]), 32'(e.st));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        check_all();
    endtask

    task automatic start_scan(input int d, input int l, input bit c);
        dwell      = 8'(d);
        last_idx   = 4'(l);
        continuous = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        // Clock/reset
        reset_models();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1 check_all();

        // Single pass, dwell 3, three indices
        start_scan(3, 2, 1'b0);
        repeat (16) tick();

        // Dwell 0 behaves as 1, single index
        start_scan(0, 0, 1'b0);
        repeat (5) tick();

        // Continuous full range with wrap; start and input changes while busy are ignored
        start_scan(2, 15, 1'b1);
        repeat (40) tick();
        dwell = 8'd7; last_idx = 4'd3; continuous = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (60) tick();
        do_stop();
        repeat (2) tick();

        // Stop at the second cycle of index 5, then restart from zero
        start_scan(2, 15, 1'b1);
        repeat (16) tick();
        do_stop();
        repeat (2) tick();
        start_scan(1, 3, 1'b0);
        repeat (12) tick();

        // start and stop together in IDLE: stays idle
        dwell = 8'd2; last_idx = 4'd4; continuous = 1'b1;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (3) tick();

        // Randomized scans with random stop points and input churn while busy
        for (int it = 0; it < 25; it++) begin
            int n;
            start_scan(int'($urandom_range(0, 4)), int'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)));
            n = int'($urandom_range(1, 90));
            for (int c = 0; c < n; c++) begin
                dwell      = 8'($urandom_range(0, 255));
                last_idx   = 4'($urandom_range(0, 15));
                continuous = 1'($urandom_range(0, 1));
                start      = ($urandom_range(0, 9) == 0);
                tick();
                start      = 1'b0;
            end
            do_stop();
            tick();
        end

        // Asynchronous reset mid-ACTIVE, applied between clock edges
        start_scan(4, 5, 1'b1);
        repeat (7) tick();
        #2 rst = 1'b1;
        reset_models();
        #1 check_all();
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check_all();
        start_scan(2, 1, 1'b0);
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
